// File: rtl/thread_sched_nmt1.sv
// Per-thread PC context store with a round-robin scheduler for the
// near-memory-threading fetch stage. It parks the running thread on a memory
// stall or a halt, then picks the next READY thread after the current one.
module thread_sched_nmt1 #(
   parameter int              NUM_THREADS = 4,
   parameter int              TID_W       = 2,
   parameter int              PC_W        = 32,
   parameter logic [PC_W-1:0] PC_BASE     = 32'h0000_0000,
   parameter logic [PC_W-1:0] PC_STRIDE   = 32'h0000_0400
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mem_stall,
   input  logic [PC_W-1:0]        stall_pc,
   input  logic                   mem_done,
   input  logic [TID_W-1:0]       mem_done_tid,
   input  logic                   halt,
   input  logic [TID_W-1:0]       halt_tid,
   output logic                   context_switch,
   output logic [PC_W-1:0]        current_thread_pc,
   output logic [TID_W-1:0]       current_tid,
   output logic                   thread_valid,
   output logic [NUM_THREADS-1:0] ready_mask
);

   typedef enum logic [1:0] {TH_READY, TH_RUNNING, TH_WAITING, TH_HALTED} th_state_t;
   typedef enum logic [1:0] {S_SELECT, S_RUN, S_IDLE} fsm_t;

   th_state_t         th_state [NUM_THREADS];
   th_state_t         th_next  [NUM_THREADS];
   logic [PC_W-1:0]   pc       [NUM_THREADS];

   fsm_t              fsm, fsm_next;
   logic [TID_W-1:0]  rr_ptr, rr_ptr_next;
   logic              cs_next, valid_next;
   logic [TID_W-1:0]  tid_next;
   logic [PC_W-1:0]   cpc_next;

   logic              found;
   logic [TID_W-1:0]  sel_tid;
   logic [TID_W-1:0]  probe;
   logic              sel_take;
   logic              run_halt;
   logic              run_stall;

   // Start PC of a thread; wraps naturally at PC_W bits.
   function automatic logic [PC_W-1:0] start_pc(input int idx);
      return PC_BASE + PC_W'(idx) * PC_STRIDE;
   endfunction

   // Round-robin search over registered states, starting just after the last pick.
   always_comb begin
      found   = 1'b0;
      sel_tid = '0;
      probe   = '0;
      for (int k = 1; k <= NUM_THREADS; k++) begin
         probe = rr_ptr + TID_W'(k);
         if (!found && th_state[probe] == TH_READY) begin
            found   = 1'b1;
            sel_tid = probe;
         end
      end
   end

   // Events that act on the running thread; halt outranks the stall.
   always_comb begin
      sel_take  = (fsm == S_SELECT) && found;
      run_halt  = (fsm == S_RUN) && halt && (halt_tid == current_tid);
      run_stall = (fsm == S_RUN) && mem_stall && !run_halt;
   end

   // Per-thread next state; halt beats mem_done on the same thread.
   always_comb begin
      for (int i = 0; i < NUM_THREADS; i++) begin
         th_next[i] = th_state[i];
         if (sel_take && sel_tid == TID_W'(i)) begin
            th_next[i] = TH_RUNNING;
         end else if (run_halt && current_tid == TID_W'(i)) begin
            th_next[i] = TH_HALTED;
         end else if (run_stall && current_tid == TID_W'(i)) begin
            th_next[i] = TH_WAITING;
         end else if (halt && halt_tid == TID_W'(i) &&
                      (th_state[i] == TH_READY || th_state[i] == TH_WAITING)) begin
            th_next[i] = TH_HALTED;
         end else if (mem_done && mem_done_tid == TID_W'(i) &&
                      th_state[i] == TH_WAITING) begin
            th_next[i] = TH_READY;
         end
      end
   end

   // Thread state and saved-PC registers; a stall saves the resume PC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            th_state[i] <= TH_READY;
            pc[i]       <= start_pc(i);
         end
      end else begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            th_state[i] <= th_next[i];
         end
         if (run_stall) begin
            pc[current_tid] <= stall_pc;
         end
      end
   end

   // Scheduler next state and next values of the registered outputs.
   always_comb begin
      fsm_next    = fsm;
      rr_ptr_next = rr_ptr;
      cs_next     = 1'b0;
      valid_next  = thread_valid;
      tid_next    = current_tid;
      cpc_next    = current_thread_pc;
      case (fsm)
         S_SELECT: begin
            if (found) begin
               tid_next    = sel_tid;
               rr_ptr_next = sel_tid;
               cpc_next    = pc[sel_tid];
               cs_next     = 1'b1;
               valid_next  = 1'b1;
               fsm_next    = S_RUN;
            end else begin
               valid_next  = 1'b0;
               fsm_next    = S_IDLE;
            end
         end
         S_RUN: begin
            if (run_halt || run_stall) begin
               valid_next = 1'b0;
               fsm_next   = S_SELECT;
            end
         end
         S_IDLE: begin
            if (|ready_mask) begin
               fsm_next = S_SELECT;
            end
         end
         default: begin
            fsm_next = S_SELECT;
         end
      endcase
   end

   // Scheduler state and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm               <= S_SELECT;
         rr_ptr            <= TID_W'(NUM_THREADS - 1);
         context_switch    <= 1'b0;
         thread_valid      <= 1'b0;
         current_tid       <= '0;
         current_thread_pc <= PC_BASE;
      end else begin
         fsm               <= fsm_next;
         rr_ptr            <= rr_ptr_next;
         context_switch    <= cs_next;
         thread_valid      <= valid_next;
         current_tid       <= tid_next;
         current_thread_pc <= cpc_next;
      end
   end

   // READY mask decoded straight from the registered thread states.
   always_comb begin
      ready_mask = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         ready_mask[i] = (th_state[i] == TH_READY);
      end
   end

endmodule

// File: tb/tb_thread_sched_nmt1.sv
// Self-checking bench for thread_sched_nmt1: directed scenarios plus random
// traffic, all compared against a behavioural model of the scheduler.
module tb_thread_sched_nmt1;

   localparam int N = 4;

   // Model encodings (bench-local, independent of the design).
   localparam int ST_READY = 0, ST_RUN = 1, ST_WAIT = 2, ST_HALT = 3;
   localparam int M_SEL = 0, M_RUN = 1, M_IDLE = 2;

   logic        clk;
   logic        reset;
   logic        mem_stall;
   logic [31:0] stall_pc;
   logic        mem_done;
   logic [1:0]  mem_done_tid;
   logic        halt;
   logic [1:0]  halt_tid;
   logic        context_switch;
   logic [31:0] current_thread_pc;
   logic [1:0]  current_tid;
   logic        thread_valid;
   logic [3:0]  ready_mask;

   int n_checks = 0;
   int n_errors = 0;

   int          m_st [N];
   logic [31:0] m_pc [N];
   int          m_mode, m_ptr, m_tid;
   logic        m_cs, m_valid;
   logic [31:0] m_cpc;

   thread_sched_nmt1 dut (
      .clk               (clk),
      .reset             (reset),
      .mem_stall         (mem_stall),
      .stall_pc          (stall_pc),
      .mem_done          (mem_done),
      .mem_done_tid      (mem_done_tid),
      .halt              (halt),
      .halt_tid          (halt_tid),
      .context_switch    (context_switch),
      .current_thread_pc (current_thread_pc),
      .current_tid       (current_tid),
      .thread_valid      (thread_valid),
      .ready_mask        (ready_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i] = ST_READY;
         m_pc[i] = 32'h400 * i;
      end
      m_mode  = M_SEL;
      m_ptr   = N - 1;
      m_tid   = 0;
      m_cpc   = 32'h0;
      m_cs    = 1'b0;
      m_valid = 1'b0;
   endtask

   // One clock of scheduler behaviour, rules applied as successive overrides.
   task automatic model_step(input logic ms, input logic [31:0] spc, input logic md,
                             input int mdt, input logic h, input int ht);
      int  old_st [N];
      bool_found: begin end
      for (int i = 0; i < N; i++) old_st[i] = m_st[i];
      if (md && old_st[mdt] == ST_WAIT) m_st[mdt] = ST_READY;
      if (h && (old_st[ht] == ST_READY || old_st[ht] == ST_WAIT)) m_st[ht] = ST_HALT;
      m_cs = 1'b0;
      if (m_mode == M_SEL) begin
         int pick;
         pick = -1;
         for (int k = 1; k <= N; k++) begin
            if (pick < 0 && old_st[(m_ptr + k) % N] == ST_READY) pick = (m_ptr + k) % N;
         end
         if (pick >= 0) begin
            m_st[pick] = ST_RUN;
            m_tid   = pick;
            m_ptr   = pick;
            m_cpc   = m_pc[pick];
            m_cs    = 1'b1;
            m_valid = 1'b1;
            m_mode  = M_RUN;
         end else begin
            m_valid = 1'b0;
            m_mode  = M_IDLE;
         end
      end else if (m_mode == M_RUN) begin
         if (h && ht == m_tid) begin
            m_st[m_tid] = ST_HALT;
            m_valid = 1'b0;
            m_mode  = M_SEL;
         end else if (ms) begin
            m_pc[m_tid] = spc;
            m_st[m_tid] = ST_WAIT;
            m_valid = 1'b0;
            m_mode  = M_SEL;
         end
      end else begin
         for (int i = 0; i < N; i++) if (old_st[i] == ST_READY) m_mode = M_SEL;
      end
   endtask

   task automatic compare_all();
      logic [3:0] exp_mask;
      for (int i = 0; i < N; i++) exp_mask[i] = (m_st[i] == ST_READY);
      check_val("context_switch", context_switch, m_cs);
      check_val("current_tid", current_tid, m_tid);
      check_val("current_thread_pc", current_thread_pc, m_cpc);
      check_val("thread_valid", thread_valid, m_valid);
      check_val("ready_mask", ready_mask, exp_mask);
   endtask

   // Drive one cycle of inputs at the falling edge, step the model on the
   // rising edge, compare at the next falling edge.
   task automatic do_cycle(input logic ms, input logic [31:0] spc, input logic md,
                           input int mdt, input logic h, input int ht);
      mem_stall    = ms;
      stall_pc     = spc;
      mem_done     = md;
      mem_done_tid = 2'(mdt);
      halt         = h;
      halt_tid     = 2'(ht);
      @(posedge clk);
      model_step(ms, spc, md, mdt, h, ht);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_cycle();
      do_cycle(1'b0, 32'h0, 1'b0, 0, 1'b0, 0);
   endtask

   // Assert reset between edges (called at a falling edge), release one cycle later.
   task automatic async_reset();
      mem_stall = 1'b0; mem_done = 1'b0; halt = 1'b0;
      #2 reset = 1'b1;
      #1 model_reset();
      compare_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; mem_stall = 1'b0; stall_pc = '0; mem_done = 1'b0;
      mem_done_tid = '0; halt = 1'b0; halt_tid = '0;
      model_reset();
      repeat (2) @(negedge clk);

      // Reset values and release.
      check_val("rst_cs", context_switch, 1'b0);
      check_val("rst_tid", current_tid, 2'd0);
      check_val("rst_pc", current_thread_pc, 32'h0);
      check_val("rst_valid", thread_valid, 1'b0);
      check_val("rst_mask", ready_mask, 4'b1111);
      reset = 1'b0;
      idle_cycle();
      check_val("rel_cs", context_switch, 1'b1);
      check_val("rel_tid", current_tid, 2'd0);
      check_val("rel_pc", current_thread_pc, 32'h0);
      check_val("rel_valid", thread_valid, 1'b1);
      check_val("rel_mask", ready_mask, 4'b1110);

      // Stall thread 0, switch to thread 1 two cycles later.
      do_cycle(1'b1, 32'h10, 1'b0, 0, 1'b0, 0);
      check_val("stall_valid_low", thread_valid, 1'b0);
      idle_cycle();
      check_val("sw1_cs", context_switch, 1'b1);
      check_val("sw1_tid", current_tid, 2'd1);
      check_val("sw1_pc", current_thread_pc, 32'h400);
      check_val("sw1_mask", ready_mask, 4'b1100);
      idle_cycle();
      check_val("sw1_pulse_end", context_switch, 1'b0);

      // Stall the rest, reach IDLE, wake thread 2.
      do_cycle(1'b1, 32'h14, 1'b0, 0, 1'b0, 0); idle_cycle();
      do_cycle(1'b1, 32'h18, 1'b0, 0, 1'b0, 0); idle_cycle();
      do_cycle(1'b1, 32'h1C, 1'b0, 0, 1'b0, 0); idle_cycle();
      check_val("idle_valid", thread_valid, 1'b0);
      check_val("idle_mask", ready_mask, 4'b0000);
      do_cycle(1'b0, 32'h0, 1'b1, 2, 1'b0, 0);
      idle_cycle();
      check_val("wake_no_cs_yet", context_switch, 1'b0);
      idle_cycle();
      check_val("wake_cs", context_switch, 1'b1);
      check_val("wake_tid", current_tid, 2'd2);
      check_val("wake_pc", current_thread_pc, 32'h18);

      // Round-robin wrap: thread 3 runs, 1 waits, 0 and 2 ready.
      do_cycle(1'b0, 32'h0, 1'b1, 3, 1'b0, 0);
      do_cycle(1'b1, 32'h20, 1'b0, 0, 1'b0, 0); idle_cycle();
      check_val("rr_t3_tid", current_tid, 2'd3);
      check_val("rr_t3_pc", current_thread_pc, 32'h1C);
      do_cycle(1'b0, 32'h0, 1'b1, 0, 1'b0, 0);
      do_cycle(1'b0, 32'h0, 1'b1, 2, 1'b0, 0);
      check_val("rr_setup_mask", ready_mask, 4'b0101);
      do_cycle(1'b1, 32'h30, 1'b0, 0, 1'b0, 0); idle_cycle();
      check_val("rr_wrap_tid", current_tid, 2'd0);
      check_val("rr_wrap_pc", current_thread_pc, 32'h10);

      // Halt and stall together on the running thread: halt wins.
      do_cycle(1'b1, 32'hAA, 1'b0, 0, 1'b1, 0); idle_cycle();
      check_val("prio_tid", current_tid, 2'd2);
      check_val("prio_pc", current_thread_pc, 32'h20);
      check_val("prio_mask", ready_mask, 4'b0000);
      do_cycle(1'b0, 32'h0, 1'b1, 1, 1'b0, 0);
      check_val("done_wait_mask", ready_mask, 4'b0010);
      do_cycle(1'b0, 32'h0, 1'b1, 1, 1'b0, 0);
      check_val("done_ready_mask", ready_mask, 4'b0010);
      check_val("done_ready_tid", current_tid, 2'd2);

      // Asynchronous reset mid-RUN.
      #2 reset = 1'b1;
      #1;
      check_val("arst_cs", context_switch, 1'b0);
      check_val("arst_tid", current_tid, 2'd0);
      check_val("arst_pc", current_thread_pc, 32'h0);
      check_val("arst_valid", thread_valid, 1'b0);
      check_val("arst_mask", ready_mask, 4'b1111);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      idle_cycle();
      check_val("arel_cs", context_switch, 1'b1);
      check_val("arel_tid", current_tid, 2'd0);
      check_val("arel_pc", current_thread_pc, 32'h0);

      // Random traffic with periodic resets.
      for (int c = 0; c < 3000; c++) begin
         logic r_h;
         if (c % 250 == 249) async_reset();
         r_h = ($urandom_range(0, 39) == 0) && (m_mode != M_SEL);
         do_cycle($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3), r_h, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
